// File: rtl/pagerank_pkg.sv
// Shared PageRank types and fixed-point helpers used by the gather, apply and normalize blocks.
package pagerank_pkg;

    localparam int FRAC_BITS = 16;

    typedef logic [63:0] rank_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ACCUM,
        ST_DRAIN,
        ST_APPLY,
        ST_DONE
    } gather_state_t;

    function automatic rank_t sat_add64(input rank_t a, input rank_t b);
        logic [64:0] sum;
        sum = {1'b0, a} + {1'b0, b};
        return sum[64] ? '1 : sum[63:0];
    endfunction

endpackage

// File: rtl/gather_fifo.sv
// Small synchronous FIFO with registered full/empty flags; pop data is the current head entry.
module gather_fifo #(
    parameter int WIDTH = 96,
    parameter int DEPTH = 4
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             full,
    output logic             empty
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [PTR_W:0] FULL_CNT = DEPTH[PTR_W:0];

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W:0]   count_q, count_d;
    logic             full_q, full_d;
    logic             empty_q, empty_d;
    logic             push_ok, pop_ok;

    assign push_ok  = push && !full_q;
    assign pop_ok   = pop && !empty_q;
    assign pop_data = mem_q[rd_ptr_q];
    assign full     = full_q;
    assign empty    = empty_q;

    always_comb begin
        wr_ptr_d = push_ok ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
        rd_ptr_d = pop_ok  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
        case ({push_ok, pop_ok})
            2'b10:   count_d = count_q + (PTR_W+1)'(1);
            2'b01:   count_d = count_q - (PTR_W+1)'(1);
            default: count_d = count_q;
        endcase
        full_d  = (count_d == FULL_CNT);
        empty_d = (count_d == '0);
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            full_q   <= full_d;
            empty_q  <= empty_d;
        end
    end

    // Storage needs no reset: the pointers and empty flag gate every read.
    always_ff @(posedge clock) begin
        if (push_ok)
            mem_q[wr_ptr_q] <= push_data;
    end

endmodule

// File: rtl/pagerank_gather.sv
// PageRank gather stage: buffers scatter beats, accumulates per-node contributions,
// then applies damping one node per cycle to form the next rank vector.
module pagerank_gather
    import pagerank_pkg::*;
#(
    parameter int          NODES_IN_GRAPH = 32,
    parameter int          FIFO_DEPTH     = 4,
    parameter logic [15:0] DAMPING        = 16'hD999,
    parameter logic [63:0] BASE_TERM      = 64'h1333,
    parameter logic [63:0] INIT_RANK      = 64'h0
) (
    input  logic                         clock,
    input  logic                         reset_n,
    input  logic                         gather_enable,
    input  logic                         next_iteration,
    input  logic                         in_valid,
    input  logic [31:0]                  in_node_id,
    input  logic [63:0]                  in_value,
    output logic                         in_ready,
    input  logic                         scatter_done,
    output logic [64*NODES_IN_GRAPH-1:0] page_rank_new,
    output logic                         iteration_done,
    output logic                         busy,
    output logic                         drop_flag
);

    localparam int IDX_W = (NODES_IN_GRAPH > 1) ? $clog2(NODES_IN_GRAPH) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NODES_IN_GRAPH - 1);

    gather_state_t    state_q, state_d;
    logic [IDX_W-1:0] k_q, k_d;
    rank_t            acc_q [NODES_IN_GRAPH];
    rank_t            acc_d [NODES_IN_GRAPH];
    rank_t            prn_q [NODES_IN_GRAPH];
    rank_t            prn_d [NODES_IN_GRAPH];
    logic             drop_q, drop_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    logic             fifo_push, fifo_pop, fifo_full, fifo_empty;
    logic [95:0]      fifo_rdata;
    logic [31:0]      pop_id;
    rank_t            pop_val;
    logic [79:0]      damp_prod;
    rank_t            apply_val;

    assign in_ready  = (state_q == ST_ACCUM) && !fifo_full && gather_enable;
    assign fifo_push = in_valid && in_ready;
    assign pop_id    = fifo_rdata[95:64];
    assign pop_val   = fifo_rdata[63:0];

    gather_fifo #(
        .WIDTH (96),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clock     (clock),
        .reset_n   (reset_n),
        .push      (fifo_push),
        .push_data ({in_node_id, in_value}),
        .pop       (fifo_pop),
        .pop_data  (fifo_rdata),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    // Full 80-bit product keeps the integer bits of acc*d before dropping the Q0.16 fraction.
    always_comb begin
        damp_prod = 80'(acc_q[k_q]) * 80'(DAMPING);
        apply_val = sat_add64(BASE_TERM, rank_t'(damp_prod >> FRAC_BITS));
    end

    always_comb begin
        state_d  = state_q;
        k_d      = k_q;
        acc_d    = acc_q;
        prn_d    = prn_q;
        drop_d   = drop_q;
        fifo_pop = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (gather_enable)
                    state_d = ST_ACCUM;
            end
            ST_ACCUM: begin
                if (gather_enable) begin
                    fifo_pop = !fifo_empty;
                    if (scatter_done)
                        state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (gather_enable) begin
                    if (fifo_empty)
                        state_d = ST_APPLY;
                    else
                        fifo_pop = 1'b1;
                end
            end
            ST_APPLY: begin
                if (gather_enable) begin
                    prn_d[k_q] = apply_val;
                    acc_d[k_q] = '0;
                    if (k_q == LAST_IDX) begin
                        k_d     = '0;
                        state_d = ST_DONE;
                    end else begin
                        k_d = k_q + IDX_W'(1);
                    end
                end
            end
            ST_DONE: begin
                if (gather_enable && next_iteration) begin
                    state_d = ST_IDLE;
                    drop_d  = 1'b0;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (fifo_pop) begin
            if (pop_id < 32'(NODES_IN_GRAPH))
                acc_d[pop_id[IDX_W-1:0]] = sat_add64(acc_q[pop_id[IDX_W-1:0]], pop_val);
            else
                drop_d = 1'b1;
        end

        busy_d = (state_d == ST_ACCUM) || (state_d == ST_DRAIN) || (state_d == ST_APPLY);
        done_d = (state_d == ST_DONE);
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
            k_q     <= '0;
            drop_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            for (int i = 0; i < NODES_IN_GRAPH; i++) begin
                acc_q[i] <= '0;
                prn_q[i] <= INIT_RANK;
            end
        end else begin
            state_q <= state_d;
            k_q     <= k_d;
            drop_q  <= drop_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            acc_q   <= acc_d;
            prn_q   <= prn_d;
        end
    end

    assign iteration_done = done_q;
    assign busy           = busy_q;
    assign drop_flag      = drop_q;

    for (genvar g = 0; g < NODES_IN_GRAPH; g++) begin : g_prn
        assign page_rank_new[g*64 +: 64] = prn_q[g];
    end

endmodule

// File: tb/tb_pagerank_gather.sv
// Randomized bench for pagerank_gather against an array-based model of the gather/apply rules.
module tb_pagerank_gather;

    localparam int          N    = 32;
    localparam logic [15:0] D    = 16'hD999;
    localparam logic [63:0] BASE = 64'h1333;
    localparam logic [63:0] INIT = 64'h0;

    logic            clock = 1'b0;
    logic            reset_n = 1'b0;
    logic            gather_enable = 1'b0;
    logic            next_iteration = 1'b0;
    logic            in_valid = 1'b0;
    logic [31:0]     in_node_id = '0;
    logic [63:0]     in_value = '0;
    logic            scatter_done = 1'b0;
    logic            in_ready, iteration_done, busy, drop_flag;
    logic [64*N-1:0] page_rank_new;

    int errs = 0;
    int checks = 0;

    logic [63:0] macc [N];
    logic [63:0] mprn [N];
    bit          mdrop = 1'b0;

    pagerank_gather dut (
        .clock          (clock),
        .reset_n        (reset_n),
        .gather_enable  (gather_enable),
        .next_iteration (next_iteration),
        .in_valid       (in_valid),
        .in_node_id     (in_node_id),
        .in_value       (in_value),
        .in_ready       (in_ready),
        .scatter_done   (scatter_done),
        .page_rank_new  (page_rank_new),
        .iteration_done (iteration_done),
        .busy           (busy),
        .drop_flag      (drop_flag)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] ref_sat(input logic [64:0] s);
        return s[64] ? 64'hFFFF_FFFF_FFFF_FFFF : s[63:0];
    endfunction

    function automatic logic [63:0] ref_apply(input logic [63:0] a);
        logic [79:0] p;
        p = {16'h0, a} * {64'h0, D};
        return ref_sat({1'b0, BASE} + {1'b0, p[79:16]});
    endfunction

    function automatic logic [63:0] prn(input int k);
        return page_rank_new[k*64 +: 64];
    endfunction

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic model_reset();
        for (int k = 0; k < N; k++) begin
            macc[k] = '0;
            mprn[k] = INIT;
        end
        mdrop = 1'b0;
    endtask

    task automatic check_all(input string tag);
        for (int k = 0; k < N; k++)
            chk($sformatf("%s[%0d]", tag, k), prn(k), mprn[k]);
    endtask

    // Present one beat and hold it until accepted; optionally raise scatter_done on the accepting edge.
    task automatic send_beat(input logic [31:0] id, input logic [63:0] v, input bit with_done);
        int w = 0;
        in_valid = 1'b1;
        in_node_id = id;
        in_value = v;
        @(negedge clock);
        while (!in_ready && w < 50) begin
            @(negedge clock);
            w++;
        end
        if (!in_ready) begin
            chk("beat_accept_timeout", 64'(in_ready), 64'(1));
        end else begin
            if (id < N) macc[id] = ref_sat({1'b0, macc[id]} + {1'b0, v});
            else        mdrop = 1'b1;
            if (with_done) scatter_done = 1'b1;
        end
        @(posedge clock);
        #1;
        in_valid = 1'b0;
        scatter_done = 1'b0;
    endtask

    task automatic start_iter();
        gather_enable = 1'b1;
        tick();
        chk("busy_in_accum", 64'(busy), 64'(1));
    endtask

    task automatic scatter_drained();
        tick(); tick(); tick();
        scatter_done = 1'b1;
        tick();
        scatter_done = 1'b0;
    endtask

    task automatic run_to_done(input int exp_lat);
        int cnt = 0;
        while (!iteration_done && cnt < 400) begin
            tick();
            cnt++;
        end
        chk("done_latency", 64'(cnt), 64'(exp_lat));
        for (int k = 0; k < N; k++) begin
            mprn[k] = ref_apply(macc[k]);
            macc[k] = '0;
        end
        check_all("prn");
        chk("drop_flag", 64'(drop_flag), 64'(mdrop));
        chk("busy_in_done", 64'(busy), 64'(0));
    endtask

    task automatic next_iter();
        tick();
        chk("done_hold", 64'(iteration_done), 64'(1));
        next_iteration = 1'b1;
        tick();
        next_iteration = 1'b0;
        mdrop = 1'b0;
        chk("done_fall", 64'(iteration_done), 64'(0));
        chk("drop_clear", 64'(drop_flag), 64'(0));
    endtask

    task automatic random_beat(input bit with_done);
        logic [31:0] id;
        logic [63:0] v;
        id = ($urandom_range(0, 9) == 0) ? 32'(N + $urandom_range(0, 100)) : 32'($urandom_range(0, N-1));
        v  = ($urandom_range(0, 3) == 0) ? {$urandom(), $urandom()} : 64'($urandom_range(0, 32'hFFFFF));
        send_beat(id, v, with_done);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        model_reset();
        tick(); tick();
        chk("rst_in_ready", 64'(in_ready), 64'(0));
        chk("rst_done", 64'(iteration_done), 64'(0));
        chk("rst_busy", 64'(busy), 64'(0));
        chk("rst_drop", 64'(drop_flag), 64'(0));
        check_all("rst_prn");
        reset_n = 1'b1;
        tick();

        // Single beat, drained before scatter_done.
        start_iter();
        send_beat(32'd3, 64'h10000, 1'b0);
        scatter_drained();
        run_to_done(N + 1);
        chk("single_node3", prn(3), 64'hECCC);
        chk("single_node0", prn(0), 64'h1333);
        next_iter();
        tick();
        check_all("idle_stable");

        // Back-to-back updates to one node.
        start_iter();
        for (int i = 0; i < 4; i++) send_beat(32'd5, 64'h4000, 1'b0);
        scatter_drained();
        run_to_done(N + 1);
        chk("b2b_node5", prn(5), 64'hECCC);
        next_iter();

        // Enable low freezes acceptance; a buffered beat survives the freeze.
        start_iter();
        gather_enable = 1'b0;
        in_valid = 1'b1;
        in_node_id = 32'd7;
        in_value = 64'h1000;
        for (int i = 0; i < 3; i++) begin
            @(negedge clock);
            chk("frozen_in_ready", 64'(in_ready), 64'(0));
        end
        tick();
        chk("frozen_busy", 64'(busy), 64'(1));
        gather_enable = 1'b1;
        for (int i = 0; i < 4; i++) send_beat(32'd7, 64'h1000, 1'b0);
        gather_enable = 1'b0;
        tick(); tick(); tick();
        gather_enable = 1'b1;
        scatter_drained();
        run_to_done(N + 1);
        chk("freeze_node7", prn(7), 64'h4999);
        next_iter();

        // Out-of-range id.
        start_iter();
        send_beat(32'd40, 64'h12345, 1'b0);
        scatter_drained();
        run_to_done(N + 1);
        chk("oor_drop", 64'(drop_flag), 64'(1));
        next_iter();

        // Saturating accumulation.
        start_iter();
        send_beat(32'd0, 64'hFFFF_FFFF_FFFF_0000, 1'b0);
        send_beat(32'd0, 64'hFFFF_FFFF_FFFF_0000, 1'b0);
        scatter_drained();
        run_to_done(N + 1);
        chk("sat_node0", prn(0), 64'hD999_0000_0000_1332);
        next_iter();

        // Randomized iterations; odd ones end on a beat coincident with scatter_done.
        for (int it = 0; it < 4; it++) begin
            int nb;
            nb = $urandom_range(2, 12);
            start_iter();
            for (int b = 0; b < nb - 1; b++) random_beat(1'b0);
            if (it % 2 == 1) begin
                random_beat(1'b1);
                run_to_done(N + 2);
            end else begin
                random_beat(1'b0);
                scatter_drained();
                run_to_done(N + 1);
            end
            next_iter();
        end

        // Coincident beat, then reset in the middle of APPLY.
        start_iter();
        send_beat(32'd2, 64'h30000, 1'b0);
        send_beat(32'd9, 64'h20000, 1'b1);
        for (int i = 0; i < N/2; i++) tick();
        chk("pre_rst_busy", 64'(busy), 64'(1));
        gather_enable = 1'b0;
        reset_n = 1'b0;
        #1;
        model_reset();
        chk("mid_rst_busy", 64'(busy), 64'(0));
        chk("mid_rst_done", 64'(iteration_done), 64'(0));
        chk("mid_rst_drop", 64'(drop_flag), 64'(0));
        chk("mid_rst_in_ready", 64'(in_ready), 64'(0));
        check_all("mid_rst_prn");
        tick();
        reset_n = 1'b1;
        tick(); tick();
        chk("post_rst_idle_busy", 64'(busy), 64'(0));

        // Accumulators must start from zero after the reset.
        start_iter();
        send_beat(32'd9, 64'h10000, 1'b0);
        scatter_drained();
        run_to_done(N + 1);
        chk("post_rst_node9", prn(9), 64'hECCC);
        next_iter();

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
